// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared types and helpers for the ALU execute-stage sequencer:
//   opcode_t  - the 16 instruction opcodes (bits [15:12] of the instruction)
//   state_t   - sequencer states
//   FLAG_*    - bit positions inside the 3-bit flag register
//   sets_zvn  - opcode updates Z, N and V
//   sets_z    - opcode updates Z only (N and V retained)
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LHB    = 4'hA,
    OP_LLB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Highest opcode that is executed on the ALU (LW/SW use the adder).
  localparam logic [3:0] LAST_ALU_OP = 4'h9;

  function automatic logic sets_zvn(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB: sets_zvn = 1'b1;
      default:        sets_zvn = 1'b0;
    endcase
  endfunction

  function automatic logic sets_z(input opcode_t op);
    case (op)
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: sets_z = 1'b1;
      default:                        sets_z = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// ---------------------------------------------------------------------------
// alu_flag_reg
// Architectural V/N/Z flag register. Updated only when i_en is high, using
// the opcode class to decide which flags change.
// Ports:
//   clk, rst_n  - clock, async active-low reset (flags clear to 3'b000)
//   i_en        - capture enable (ALU result valid this edge)
//   i_opcode    - original (un-remapped) opcode of the operation
//   i_result    - ALU result
//   i_ovfl      - ALU adder overflow, only meaningful for ADD/SUB
//   o_flags     - [2]=V, [1]=N, [0]=Z
// ---------------------------------------------------------------------------
module alu_flag_reg
  import alu_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  opcode_t       i_opcode,
  input  logic [15:0]   i_result,
  input  logic          i_ovfl,
  output logic [2:0]    o_flags
);

  logic [2:0] r_flags;
  logic       w_zero;

  assign w_zero  = ~|i_result;
  assign o_flags = r_flags;

  // Flag register: ADD/SUB load all three, logic/shift ops load Z only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 3'b000;
    end else if (i_en) begin
      if (sets_zvn(i_opcode)) begin
        r_flags[FLAG_Z] <= w_zero;
        r_flags[FLAG_N] <= i_result[15];
        r_flags[FLAG_V] <= i_ovfl;
      end else if (sets_z(i_opcode)) begin
        r_flags[FLAG_Z] <= w_zero;
      end
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// alu_exec_ctrl
// Multi-cycle execute-stage sequencer for the 16-bit ALU. Accepts one
// operation on the request channel, holds the ALU inputs for ALU_LAT cycles,
// captures the result and flags, then offers it on the response channel.
// Branch/immediate opcodes return an error response; HLT halts until reset.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   req_valid/req_ready             - request handshake
//   req_opcode/req_op1/req_op2      - operation to execute
//   rsp_valid/rsp_ready             - response handshake
//   rsp_result/rsp_err              - captured result, error flag
//   alu_opcode/alu_op1/alu_op2      - registered ALU inputs
//   alu_result/alu_ovfl             - ALU outputs
//   flags                           - [2]=V, [1]=N, [0]=Z
//   halted                          - HLT executed
// ---------------------------------------------------------------------------
module alu_exec_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_opcode,
  input  logic [15:0] req_op1,
  input  logic [15:0] req_op2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  output logic [2:0]  flags,
  output logic        halted
);

  localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  opcode_t     r_opcode;
  logic [3:0]  r_alu_opcode;
  logic [15:0] r_alu_op1;
  logic [15:0] r_alu_op2;
  logic [15:0] r_rsp_result;
  logic        r_rsp_err;
  logic        w_capture;

  // Last ISSUE cycle: the ALU output is sampled at this edge.
  assign w_capture = (r_state == ISSUE) && (r_cnt == 3'd0);

  // Handshake/status outputs are pure decodes of the state register.
  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = (r_state == DONE);
  assign halted     = (r_state == HALT);
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;
  assign alu_opcode = r_alu_opcode;
  assign alu_op1    = r_alu_op1;
  assign alu_op2    = r_alu_op2;

  // Sequencer FSM with its datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 3'd0;
      r_opcode     <= OP_ADD;
      r_alu_opcode <= 4'h0;
      r_alu_op1    <= 16'h0000;
      r_alu_op2    <= 16'h0000;
      r_rsp_result <= 16'h0000;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_opcode <= opcode_t'(req_opcode);
            if (req_opcode <= LAST_ALU_OP) begin
              // LW/SW only need the address add from the ALU.
              r_alu_opcode <= (req_opcode >= 4'h8) ? 4'h0 : req_opcode;
              r_alu_op1    <= req_op1;
              r_alu_op2    <= req_op2;
              r_cnt        <= CNT_INIT;
              r_state      <= ISSUE;
            end else if (req_opcode == 4'hF) begin
              r_state <= HALT;
            end else begin
              // Not executable here: answer immediately, ALU inputs untouched.
              r_rsp_result <= 16'h0000;
              r_rsp_err    <= 1'b1;
              r_state      <= DONE;
            end
          end
        end
        ISSUE: begin
          if (w_capture) begin
            r_rsp_result <= alu_result;
            r_rsp_err    <= 1'b0;
            r_state      <= DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  alu_flag_reg u_flag_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_capture),
    .i_opcode (r_opcode),
    .i_result (alu_result),
    .i_ovfl   (alu_ovfl),
    .o_flags  (flags)
  );

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_ctrl
// Two instances: index 0 with ALU_LAT=1, index 1 with ALU_LAT=3. A small
// behavioural ALU answers the controller; a transaction-level model predicts
// every output each cycle, and directed steps pin literal values.
// ---------------------------------------------------------------------------
module tb_alu_exec_ctrl;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]       alu_ovfl, halted;
  logic [1:0][3:0]  req_opcode, alu_opcode;
  logic [1:0][15:0] req_op1, req_op2, rsp_result, alu_op1, alu_op2, alu_result;
  logic [1:0][2:0]  flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference ALU: {ovfl, result}. ovfl is deliberately noisy for non-add ops.
  function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    logic [31:0] rr;
    v = a[0] ^ b[1];
    case (op)
      4'h0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'h1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'h2: r = a ^ b;
      4'h3: r = a & b;
      4'h4: r = a << b[3:0];
      4'h5: r = 16'($signed(a) >>> b[3:0]);
      4'h6: begin rr = {a, a} >> b[3:0]; r = rr[15:0]; end
      default: r = a + b + 16'h0100;
    endcase
    return {v, r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign {alu_ovfl[g], alu_result[g]} = alu_f(alu_opcode[g], alu_op1[g], alu_op2[g]);
    alu_exec_ctrl #(.ALU_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_opcode(req_opcode[g]), .req_op1(req_op1[g]), .req_op2(req_op2[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_result(rsp_result[g]), .rsp_err(rsp_err[g]),
      .alu_opcode(alu_opcode[g]), .alu_op1(alu_op1[g]), .alu_op2(alu_op2[g]),
      .alu_result(alu_result[g]), .alu_ovfl(alu_ovfl[g]),
      .flags(flags[g]), .halted(halted[g])
    );
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // ---- transaction-level model: in-flight countdown, pending response, halt
  logic [1:0]       m_halt, m_resp, m_err;
  int               m_wait [2];
  logic [1:0][3:0]  m_op, m_alu_op;
  logic [1:0][15:0] m_a, m_b, m_res;
  logic [1:0][2:0]  m_flags;
  logic [16:0]      t;
  logic [2:0]       f;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_halt[d] <= 1'b0; m_resp[d] <= 1'b0; m_err[d] <= 1'b0; m_wait[d] <= 0;
        m_op[d] <= 4'h0; m_alu_op[d] <= 4'h0; m_a[d] <= 16'h0; m_b[d] <= 16'h0;
        m_res[d] <= 16'h0; m_flags[d] <= 3'b000;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_halt[d]) begin
          m_halt[d] <= 1'b1;
        end else if (m_resp[d]) begin
          if (rsp_ready[d]) m_resp[d] <= 1'b0;
        end else if (m_wait[d] > 0) begin
          m_wait[d] <= m_wait[d] - 1;
          if (m_wait[d] == 1) begin
            t = alu_f(m_alu_op[d], m_a[d], m_b[d]);
            f = m_flags[d];
            if (m_op[d] == 4'h0 || m_op[d] == 4'h1) f = {t[16], t[15], t[15:0] == 16'h0};
            else if (m_op[d] inside {4'h2, 4'h4, 4'h5, 4'h6}) f[0] = (t[15:0] == 16'h0);
            m_flags[d] <= f;
            m_resp[d] <= 1'b1; m_err[d] <= 1'b0; m_res[d] <= t[15:0];
          end
        end else if (req_valid[d]) begin
          if (req_opcode[d] <= 4'h9) begin
            m_wait[d]   <= lat(d);
            m_op[d]     <= req_opcode[d];
            m_alu_op[d] <= (req_opcode[d] >= 4'h8) ? 4'h0 : req_opcode[d];
            m_a[d]      <= req_op1[d];
            m_b[d]      <= req_op2[d];
          end else if (req_opcode[d] == 4'hF) begin
            m_halt[d] <= 1'b1;
          end else begin
            m_resp[d] <= 1'b1; m_err[d] <= 1'b1; m_res[d] <= 16'h0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk("req_ready", d, 32'(req_ready[d]), 32'(!m_halt[d] && !m_resp[d] && m_wait[d] == 0));
        chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(m_resp[d]));
        chk("halted", d, 32'(halted[d]), 32'(m_halt[d]));
        chk("flags", d, 32'(flags[d]), 32'(m_flags[d]));
        chk("alu_opcode", d, 32'(alu_opcode[d]), 32'(m_alu_op[d]));
        chk("alu_op1", d, 32'(alu_op1[d]), 32'(m_a[d]));
        chk("alu_op2", d, 32'(alu_op2[d]), 32'(m_b[d]));
        if (m_resp[d]) begin
          chk("rsp_result", d, 32'(rsp_result[d]), 32'(m_res[d]));
          chk("rsp_err", d, 32'(rsp_err[d]), 32'(m_err[d]));
        end
      end
    end
  end

  // ---- stimulus helpers (called at a negedge, return at a negedge)
  task automatic send(input int d, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    req_valid[d] = 1'b1; req_opcode[d] = op; req_op1[d] = a; req_op2[d] = b;
    while (req_ready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("req_accept_timeout", d, 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d, input int exp_n, input string nm);
    int n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk(nm, d, 32'(n), 32'(exp_n));
  endtask

  task automatic take(input int d);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic reset_outs(input int d);
    chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
    chk("rst_rsp_result", d, 32'(rsp_result[d]), 32'd0);
    chk("rst_rsp_err", d, 32'(rsp_err[d]), 32'd0);
    chk("rst_alu_opcode", d, 32'(alu_opcode[d]), 32'd0);
    chk("rst_alu_op1", d, 32'(alu_op1[d]), 32'd0);
    chk("rst_alu_op2", d, 32'(alu_op2[d]), 32'd0);
    chk("rst_flags", d, 32'(flags[d]), 32'd0);
    chk("rst_halted", d, 32'(halted[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_opcode = '0; req_op1 = '0; req_op2 = '0;
    #3;
    reset_outs(0);
    reset_outs(1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 0, 32'(req_ready[0]), 32'd1);

    // ADD overflow: 0x7FFF + 1
    send(0, 4'h0, 16'h7FFF, 16'h0001);
    chk("add_t1_valid", 0, 32'(rsp_valid[0]), 32'd0);
    wait_rsp(0, 1, "add_lat");
    chk("add_result", 0, 32'(rsp_result[0]), 32'h8000);
    chk("add_err", 0, 32'(rsp_err[0]), 32'd0);
    chk("add_flags", 0, 32'(flags[0]), 32'b110);
    take(0);

    // XOR to zero: Z set, N/V retained; then hold the response
    send(0, 4'h2, 16'h00FF, 16'h00FF);
    wait_rsp(0, 1, "xor_lat");
    chk("xor_result", 0, 32'(rsp_result[0]), 32'h0000);
    chk("xor_flags", 0, 32'(flags[0]), 32'b111);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 0, 32'(rsp_valid[0]), 32'd1);
      chk("hold_result", 0, 32'(rsp_result[0]), 32'h0000);
      chk("hold_ready", 0, 32'(req_ready[0]), 32'd0);
    end
    take(0);
    chk("release_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("release_valid", 0, 32'(rsp_valid[0]), 32'd0);

    // Branch opcode: error response one cycle after acceptance
    send(0, 4'hC, 16'h1234, 16'h5678);
    chk("err_valid", 0, 32'(rsp_valid[0]), 32'd1);
    chk("err_flag", 0, 32'(rsp_err[0]), 32'd1);
    chk("err_result", 0, 32'(rsp_result[0]), 32'd0);
    chk("err_flags", 0, 32'(flags[0]), 32'b111);
    chk("err_alu_op", 0, 32'(alu_opcode[0]), 32'h2);
    chk("err_alu_op1", 0, 32'(alu_op1[0]), 32'h00FF);
    take(0);

    // Randomised traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        op = 4'($urandom_range(0, 14));
        a  = 16'($urandom);
        b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
        send(d, op, a, b);
        wait_rsp(d, (op <= 4'h9) ? lat(d) : 0, "rand_lat");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        take(d);
      end
    end

    // ALU_LAT=3: full op, then reset in the second ISSUE cycle
    send(1, 4'h0, 16'h0102, 16'h0304);
    wait_rsp(1, 3, "lat3_lat");
    chk("lat3_result", 1, 32'(rsp_result[1]), 32'h0406);
    take(1);
    send(1, 4'h4, 16'h0F0F, 16'h0004);
    chk("iss1_opcode", 1, 32'(alu_opcode[1]), 32'h4);
    @(negedge clk);
    chk("iss2_op1", 1, 32'(alu_op1[1]), 32'h0F0F);
    rst_n = 1'b0;
    #1;
    reset_outs(1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 1, 32'(rsp_valid[1]), 32'd0);
    end
    send(1, 4'h1, 16'h0005, 16'h0005);
    wait_rsp(1, 3, "sub_lat");
    chk("sub_result", 1, 32'(rsp_result[1]), 32'h0000);
    chk("sub_flags", 1, 32'(flags[1]), 32'b001);
    take(1);

    // HLT: stays halted with requests pending until reset
    send(0, 4'hF, 16'h0000, 16'h0000);
    chk("hlt_halted", 0, 32'(halted[0]), 32'd1);
    chk("hlt_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    req_valid[0] = 1'b1; req_opcode[0] = 4'h0;
    repeat (10) begin
      chk("hlt_ready", 0, 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("hlt_rst_halted", 0, 32'(halted[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_halted", 0, 32'(halted[0]), 32'd0);
    chk("post_flags", 0, 32'(flags[0]), 32'd0);
    chk("post_ready", 0, 32'(req_ready[0]), 32'd1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
